data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of the data memory: M0 (CPU core) and M1 (loader/DMA)
// share one combinational memory port, with bounded hold time and alternating tie-break.
module data_mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        M0Req,
  input  logic        M1Req,
  input  logic        M0WE,
  input  logic        M1WE,
  input  logic [31:0] M0Addr,
  input  logic [31:0] M1Addr,
  input  logic [31:0] M0WD,
  input  logic [31:0] M1WD,
  output logic        M0Gnt,
  output logic        M1Gnt,
  output logic [31:0] M0RD,
  output logic [31:0] M1RD,
  output logic        M0Valid,
  output logic        M1Valid,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD);

  owner_e      owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        m0_valid_q, m0_valid_d;
  logic        m1_valid_q, m1_valid_d;
  logic [31:0] m0_rd_q, m0_rd_d;
  logic [31:0] m1_rd_q, m1_rd_d;
  logic        hold_done;

  // Gating with Reset makes an asserted reset kill the access in the same cycle.
  assign M0Gnt   = (owner_q == OWN0) & M0Req & Reset;
  assign M1Gnt   = (owner_q == OWN1) & M1Req & Reset;
  assign M0RD    = m0_rd_q;
  assign M1RD    = m1_rd_q;
  assign M0Valid = m0_valid_q;
  assign M1Valid = m1_valid_q;

  always_comb begin
    MemA  = 32'd0;
    MemWD = 32'd0;
    MemWE = 1'b0;
    if (M0Gnt) begin
      MemA  = M0Addr;
      MemWD = M0WD;
      MemWE = M0WE;
    end else if (M1Gnt) begin
      MemA  = M1Addr;
      MemWD = M1WD;
      MemWE = M1WE;
    end
  end

  // True on the owner's last allowed cycle; >= guards against a count that ran past the limit while alone.
  assign hold_done = ({1'b0, hold_cnt_q} + 5'd1) >= HOLD_LIMIT;

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      NONE: begin
        if (M0Req && M1Req) owner_d = last_owner_q ? OWN0 : OWN1;
        else if (M0Req)     owner_d = OWN0;
        else if (M1Req)     owner_d = OWN1;
      end
      OWN0: begin
        if (M1Req && (!M0Req || (M0Gnt && hold_done))) owner_d = OWN1;
        else if (M0Req)                                owner_d = OWN0;
        else                                           owner_d = NONE;
      end
      OWN1: begin
        if (M0Req && (!M1Req || (M1Gnt && hold_done))) owner_d = OWN0;
        else if (M1Req)                                owner_d = OWN1;
        else                                           owner_d = NONE;
      end
      default: owner_d = NONE;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    if (owner_d != owner_q)
      hold_cnt_d = 4'd0;
    else if ((M0Gnt || M1Gnt) && hold_cnt_q != 4'hF)
      hold_cnt_d = hold_cnt_q + 4'd1;
    if (M0Gnt) last_owner_d = 1'b0;
    if (M1Gnt) last_owner_d = 1'b1;
  end

  always_comb begin
    m0_valid_d = M0Gnt & ~M0WE;
    m1_valid_d = M1Gnt & ~M1WE;
    m0_rd_d    = m0_valid_d ? MemRD : m0_rd_q;
    m1_rd_d    = m1_valid_d ? MemRD : m1_rd_q;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      owner_q      <= NONE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= 4'd0;
      m0_valid_q   <= 1'b0;
      m1_valid_q   <= 1'b0;
      m0_rd_q      <= 32'd0;
      m1_rd_q      <= 32'd0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      m0_valid_q   <= m0_valid_d;
      m1_valid_q   <= m1_valid_d;
      m0_rd_q      <= m0_rd_d;
      m1_rd_q      <= m1_rd_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=1
// sharing the same master inputs.
module tb_data_mem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        M0Req = 1'b0, M1Req = 1'b0, M0WE = 1'b0, M1WE = 1'b0;
  logic [31:0] M0Addr = 32'd0, M1Addr = 32'd0, M0WD = 32'd0, M1WD = 32'd0;
  logic [31:0] MemRD = 32'd0;

  logic        M0Gnt, M1Gnt, M0Valid, M1Valid, MemWE;
  logic [31:0] M0RD, M1RD, MemA, MemWD;
  logic        b_M0Gnt, b_M1Gnt, b_M0Valid, b_M1Valid, b_MemWE;
  logic [31:0] b_M0RD, b_M1RD, b_MemA, b_MemWD;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.MAX_HOLD(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .M0Req(M0Req), .M1Req(M1Req), .M0WE(M0WE), .M1WE(M1WE),
    .M0Addr(M0Addr), .M1Addr(M1Addr), .M0WD(M0WD), .M1WD(M1WD),
    .M0Gnt(M0Gnt), .M1Gnt(M1Gnt), .M0RD(M0RD), .M1RD(M1RD),
    .M0Valid(M0Valid), .M1Valid(M1Valid),
    .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
  );

  data_mem_arbiter #(.MAX_HOLD(1)) dut_b (
    .CLK(CLK), .Reset(Reset),
    .M0Req(M0Req), .M1Req(M1Req), .M0WE(M0WE), .M1WE(M1WE),
    .M0Addr(M0Addr), .M1Addr(M1Addr), .M0WD(M0WD), .M1WD(M1WD),
    .M0Gnt(b_M0Gnt), .M1Gnt(b_M1Gnt), .M0RD(b_M0RD), .M1RD(b_M1RD),
    .M0Valid(b_M0Valid), .M1Valid(b_M1Valid),
    .MemA(b_MemA), .MemWD(b_MemWD), .MemWE(b_MemWE), .MemRD(MemRD)
  );

  // Grants must never overlap, in either instance.
  always @(negedge CLK) begin
    tests_run++;
    if (((M0Gnt & M1Gnt) | (b_M0Gnt & b_M1Gnt)) !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gnt_exclusive at %0t: got a=%b%b b=%b%b expected no double grant",
               $time, M0Gnt, M1Gnt, b_M0Gnt, b_M1Gnt);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    M0Req = 1'b0; M1Req = 1'b0; M0WE = 1'b0; M1WE = 1'b0;
    M0Addr = 32'd0; M1Addr = 32'd0; M0WD = 32'd0; M1WD = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b0;
    repeat (2) next_cycle();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    M0Req = 1'b1; M0WE = 1'b1; M0Addr = 32'h44; M0WD = 32'h55;
    M1Req = 1'b1; M1WE = 1'b0;
    Reset = 1'b0;
    next_cycle();
    next_cycle();
    tests_run++;
    if ({M0Gnt, M1Gnt, MemWE} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_gnt: got gnt0=%b gnt1=%b we=%b expected 000", M0Gnt, M1Gnt, MemWE);
    end
    tests_run++;
    if ({M0Valid, M1Valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %b%b expected 00", M0Valid, M1Valid);
    end
    tests_run++;
    if (M0RD !== 32'd0 || M1RD !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rd: got %h %h expected 0 0", M0RD, M1RD);
    end
    tests_run++;
    if (MemA !== 32'd0 || MemWD !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem: got A=%h WD=%h expected 0 0", MemA, MemWD);
    end
    idle_inputs();
    Reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    M0Req = 1'b1; M0WE = 1'b0; M0Addr = 32'h10; MemRD = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (M0Gnt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_gnt_c1: got %b expected 0", M0Gnt);
    end
    next_cycle();
    tests_run++;
    if (M0Gnt !== 1'b1 || MemA !== 32'h10 || MemWE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_gnt_c2: got gnt=%b A=%h we=%b expected 1 00000010 0", M0Gnt, MemA, MemWE);
    end
    next_cycle();
    M0Req = 1'b0;
    MemRD = 32'h0BADF00D;
    #1;
    tests_run++;
    if (M0Valid !== 1'b1 || M0RD !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL read_valid_c3: got valid=%b rd=%h expected 1 deadbeef", M0Valid, M0RD);
    end
    next_cycle();
    tests_run++;
    if (M0Valid !== 1'b0 || M0RD !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL read_valid_c4: got valid=%b rd=%h expected 0 deadbeef", M0Valid, M0RD);
    end
    next_cycle();
  endtask

  task automatic test_m1_write();
    int we_cycles = 0;
    M1Req = 1'b1; M1WE = 1'b1; M1Addr = 32'h20; M1WD = 32'h12345678;
    #1;
    if (MemWE === 1'b1) we_cycles++;
    next_cycle();
    tests_run++;
    if (M1Gnt !== 1'b1 || MemWE !== 1'b1 || MemA !== 32'h20 || MemWD !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL write_port: got gnt=%b we=%b A=%h WD=%h expected 1 1 00000020 12345678",
               M1Gnt, MemWE, MemA, MemWD);
    end
    if (MemWE === 1'b1) we_cycles++;
    next_cycle();
    idle_inputs();
    #1;
    tests_run++;
    if (M1Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_no_valid: got %b expected 0", M1Valid);
    end
    if (MemWE === 1'b1) we_cycles++;
    next_cycle();
    if (MemWE === 1'b1) we_cycles++;
    tests_run++;
    if (we_cycles != 1 || M1RD !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL write_once: got we_cycles=%0d rd=%h expected 1 00000000", we_cycles, M1RD);
    end
    next_cycle();
  endtask

  task automatic test_dual_hold();
    logic [1:0] exp_gnt;
    do_reset();
    M0Req = 1'b1; M1Req = 1'b1; M0WE = 1'b0; M1WE = 1'b0; MemRD = 32'h0000CAFE;
    #1;
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL dual_c1: got %b%b expected 00", M0Gnt, M1Gnt);
    end
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      exp_gnt = (c <= 5) ? 2'b10 : 2'b01;
      tests_run++;
      if ({M0Gnt, M1Gnt} !== exp_gnt) begin
        tests_failed++;
        $display("[TB] FAIL dual_c%0d: got gnt0/1=%b%b expected %b", c, M0Gnt, M1Gnt, exp_gnt);
      end
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_handover();
    M0Req = 1'b1; M0WE = 1'b1; M0Addr = 32'h30; M0WD = 32'h1;
    next_cycle();
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL hand_own0: got %b%b expected 10", M0Gnt, M1Gnt);
    end
    M1Req = 1'b1; M1WE = 1'b0; M1Addr = 32'h34;
    next_cycle();
    M0Req = 1'b0;
    #1;
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL hand_gap: got %b%b expected 00", M0Gnt, M1Gnt);
    end
    next_cycle();
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b01 || MemA !== 32'h34) begin
      tests_failed++;
      $display("[TB] FAIL hand_own1: got %b%b A=%h expected 01 00000034", M0Gnt, M1Gnt, MemA);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_write();
    M0Req = 1'b1; M0WE = 1'b1; M0Addr = 32'h40; M0WD = 32'hCAFEF00D;
    next_cycle();
    tests_run++;
    if (MemWE !== 1'b1 || M0Gnt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstw_pre: got we=%b gnt=%b expected 1 1", MemWE, M0Gnt);
    end
    Reset = 1'b0;
    #1;
    tests_run++;
    if (MemWE !== 1'b0 || M0Gnt !== 1'b0 || MemA !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rstw_abort: got we=%b gnt=%b A=%h expected 0 0 00000000", MemWE, M0Gnt, MemA);
    end
    next_cycle();
    tests_run++;
    if (M0Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstw_valid: got %b expected 0", M0Valid);
    end
    Reset = 1'b1;
    M1Req = 1'b1; M0WE = 1'b0; M1WE = 1'b0;
    #1;
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rstw_none: got %b%b expected 00", M0Gnt, M1Gnt);
    end
    next_cycle();
    tests_run++;
    if ({M0Gnt, M1Gnt} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rstw_m0_wins: got %b%b expected 10", M0Gnt, M1Gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    logic [1:0] exp_gnt;
    do_reset();
    M0Req = 1'b1; M1Req = 1'b1; M0WE = 1'b0; M1WE = 1'b0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
      if (b_M0Gnt === 1'b1) n0++;
      if (b_M1Gnt === 1'b1) n1++;
      tests_run++;
      if ({b_M0Gnt, b_M1Gnt} !== exp_gnt) begin
        tests_failed++;
        $display("[TB] FAIL alt_c%0d: got %b%b expected %b", c, b_M0Gnt, b_M1Gnt, exp_gnt);
      end
    end
    tests_run++;
    if (n0 != 4 || n1 != 4) begin
      tests_failed++;
      $display("[TB] FAIL alt_count: got m0=%0d m1=%0d expected 4 4", n0, n1);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_m1_write();
    test_dual_hold();
    test_handover();
    test_reset_mid_write();
    test_alternate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
